// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, scan-result type and idle constant shared by the keypad scanner.
package keypad_pkg;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } scan_t;

    localparam scan_t NO_KEY = '{hit: 1'b0, code: 4'h0};

    // Indexed {row, col}
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: commits a scan result after DEBOUNCE_SCANS identical scans and pulses keyEvent on new keys.
module keypad_debounce import keypad_pkg::*; #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  scan_t      result,
    output logic [3:0] keyValue,
    output logic       keyPressed,
    output logic       keyEvent
);

    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    scan_t         cand;
    logic [SW-1:0] stable, stable_next;
    logic          commit, fresh;

    always_comb begin
        stable_next = (result == cand) ? ((stable == SW'(DEBOUNCE_SCANS)) ? stable : stable + 1'b1) : SW'(1);
        commit      = strobe && stable_next == SW'(DEBOUNCE_SCANS);
        fresh       = result.hit && (result.code != keyValue || !keyPressed);
    end

    // A saturated counter re-commits every scan; that is idempotent for a held key or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand       <= NO_KEY;
            stable     <= '0;
            keyValue   <= 4'h0;
            keyPressed <= 1'b0;
            keyEvent   <= 1'b0;
        end else begin
            keyEvent <= commit && fresh;
            if (strobe) begin
                cand   <= result;
                stable <= stable_next;
            end
            if (commit) begin
                if (result.hit) keyValue <= result.code;
                keyPressed <= result.hit;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with row synchronizer, first-hit accumulator and debounce.
// Define KEYPAD_GHOST_REJECT_EN to discard scans that see two or more pressed keys.
module keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] keyValue,
    output logic       keyPressed,
    output logic       keyEvent
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    row_s1, row_s2, act;
    logic [DW-1:0] dwell;
    logic [1:0]    c, r_lo;
    logic          sample, wrap, strobe;
    scan_t         acc, acc_next;

    always_comb begin
        act      = ~row_s2;
        sample   = dwell == DW'(SCAN_DIV - 1);
        wrap     = sample && c == 2'd3;
        r_lo     = act[0] ? 2'd0 : act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd3;
        acc_next = (!acc.hit && |act) ? scan_t'{hit: 1'b1, code: KEYMAP[{r_lo, c}]} : acc;
        col      = ~(4'b0001 << c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            dwell  <= '0;
            c      <= 2'd0;
            acc    <= NO_KEY;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            dwell  <= sample ? '0 : dwell + 1'b1;
            if (sample) begin
                c   <= c + 2'd1;
                acc <= wrap ? NO_KEY : acc_next;
            end
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic multi, multi_next;

    assign multi_next = multi || (acc.hit && |act) || (act & (act - 4'd1)) != 4'd0;
    assign strobe     = wrap && !multi_next;

    always_ff @(posedge clk) begin
        if (rst || wrap) multi <= 1'b0;
        else if (sample) multi <= multi_next;
    end
`else
    assign strobe = wrap;
`endif

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .strobe    (strobe),
        .result    (acc_next),
        .keyValue  (keyValue),
        .keyPressed(keyPressed),
        .keyEvent  (keyEvent)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scan-level keypad model with event scoreboard for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

    localparam int D = 3;

    typedef struct {
        int         n;
        logic [3:0] code;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] col, row, keyValue;
    logic       keyPressed, keyEvent;
    logic [15:0] mask = '0;
    int         n = 0, errors = 0, checks = 0;
    logic       m_kp = 1'b0;
    logic [3:0] m_kv = 4'h0;
    ev_t        evq[$];
    logic [4:0] hist[$];
    logic [3:0] keys [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .keyValue  (keyValue),
        .keyPressed(keyPressed),
        .keyEvent  (keyEvent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    // Physical matrix: a pressed key at (r,c) pulls row r low while column c is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(mask[r*4 +: 4] & ~col);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic end_scan();
        logic [4:0] res = 5'h0;
        bit found = 0, same;
`ifdef KEYPAD_GHOST_REJECT_EN
        if ($countones(mask) >= 2) return;
`endif
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!found && mask[r*4+c]) begin
                    found = 1;
                    res = {1'b1, keys[r*4+c]};
                end
        hist.push_back(res);
        if (hist.size() > D) void'(hist.pop_front());
        same = hist.size() == D;
        foreach (hist[i]) if (hist[i] != res) same = 0;
        if (same) begin
            if (res[4] && (res[3:0] != m_kv || !m_kp)) begin
                m_kv = res[3:0];
                m_kp = 1'b1;
                evq.push_back('{n, res[3:0]});
            end else if (!res[4]) m_kp = 1'b0;
        end
    endtask

    task automatic run(input logic [15:0] m, input int scans);
        for (int k = 0; k < scans; k++) begin
            mask = m;
            repeat (16) @(negedge clk);
            end_scan();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        m_kp = 1'b0;
        m_kv = 4'h0;
        hist.delete();
        evq.delete();
        rst = 1'b0;
    endtask

    initial begin
        ev_t ev;
        logic [3:0] ecol;
        forever begin
            @(negedge clk);
            #2;
            ecol = ~(4'b0001 << ((n / 4) % 4));
            chk("col", col, ecol);
            chk("keyPressed", keyPressed, m_kp);
            chk("keyValue", keyValue, m_kv);
            if (keyEvent) begin
                if (evq.size() == 0) chk("unexpected keyEvent", keyEvent, 0);
                else begin
                    ev = evq.pop_front();
                    chk("keyEvent time", n, ev.n);
                    chk("keyEvent code", keyValue, ev.code);
                end
            end else if (evq.size() != 0 && evq[0].n <= n) begin
                void'(evq.pop_front());
                chk("keyEvent missing", keyEvent, 1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] m;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(16'h0, 13);
        run(16'h1 << 5, 5);
        run(16'h0, 5);
        for (int i = 0; i < 20; i++) run((i % 2) ? (16'h1 << 9) : 16'h0, 1);
        run(16'h1 << 5, 5);
        run(16'h1 << 9, 5);
        run(16'h0, 5);
        run(16'h0013, 5);
        run(16'h0, 5);
        run(16'h1 << 5, 5);
        repeat (7) @(negedge clk);
        do_reset();
        run(16'h1 << 5, 5);
        run(16'h0, 5);
        repeat (40) begin
            case ($urandom_range(0, 9))
                0, 1, 2:       m = 16'h0;
                3, 4, 5, 6, 7: m = 16'h1 << $urandom_range(0, 15);
                default:       m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            run(m, $urandom_range(1, 5));
        end
        run(16'h0, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
